sync_fifo_flex: RTL
===================

// Module: sync_fifo_flex
// PURPOSE
// - Single-clock FIFO for same-domain buffering between pipeline stages.
// - Generalises the dual-clock FIFO: any DEPTH >= 2 (not only powers of two), fill level,
//   almost-full/almost-empty thresholds, and selectable standard or first-word-fall-through read.
// - No CDC logic: pointers, level and flags are all in the clk domain.
// PARAMETERS
// - DATA_WIDTH  8   word width in bits
// - DEPTH       16  storage words, >= 2, any integer
// - AF_LEVEL    12  almost_full asserts when level >= AF_LEVEL (1..DEPTH)
// - AE_LEVEL    2   almost_empty asserts when level <= AE_LEVEL (0..DEPTH-1)
// - FWFT        0   0 = standard read (1-cycle latency), 1 = first-word-fall-through
// PORTS
// - clk           in   1                  clock, all logic on posedge
// - rst_n         in   1                  synchronous reset, active low
// - w_en          in   1                  write request
// - w_data        in   DATA_WIDTH         write data
// - w_full        out  1                  level == DEPTH
// - almost_full   out  1                  level >= AF_LEVEL
// - r_en          in   1                  read request (FWFT: pop head word)
// - r_data        out  DATA_WIDTH         read data, registered
// - r_empty       out  1                  no word readable
// - almost_empty  out  1                  level <= AE_LEVEL
// - level         out  $clog2(DEPTH+1)    words held, incl. FWFT output register
// BEHAVIOUR
// - One clock; reset synchronous, active low. rst_n=0 at an edge: pointers=0, level=0, r_data=0,
//   r_empty=1, w_full=0, almost_empty=1, almost_full=0. Contents discarded, incl. mid-operation.
// - Write accepted iff w_en && !w_full. Full blocks the write even with a simultaneous read.
// - Read accepted iff r_en && !r_empty. Empty ignores the read even with a simultaneous write.
// - Pointers: $clog2(DEPTH) bits, wrap DEPTH-1 -> 0 explicitly (no MSB wrap bit).
//   Full/empty come from the level register, not from pointer compare.
// - level: +1 on write only, -1 on read only, unchanged on both or neither. Never > DEPTH or < 0.
// - Flags decode from the registered level. No extra latency; glitch-free at the outputs.
// - Standard mode (FWFT=0):
//   - Read accepted at edge N -> r_data = head word after edge N.
//   - r_data holds its value when no read is accepted.
//   - r_empty = (level == 0).
// - FWFT mode (FWFT=1):
//   - Output register holds the head word.
//   - Write into an empty FIFO at edge N -> r_empty=0 and r_data=word after edge N.
//   - Pop at edge N -> next word (or the word written at N, if storage was empty) appears after edge N.
//   - Popping the last word -> r_empty=1 after edge N. r_data holds the stale value.
// - Write-to-r_empty-deassert latency is 1 edge in both modes.
// CONFIGURATION
// - Macro SYNC_FIFO_FLEX_ERR_FLAGS_EN defined adds two outputs:
//   - overflow_err  out 1: sticky, set on w_en && w_full.
//   - underflow_err out 1: sticky, set on r_en && r_empty.
//   - Both cleared only by reset.
// - Macro undefined: the ports and logic are absent; ignored requests are silently dropped.
// TESTING
// - Reset, then write 0x01..0x10 (DEPTH=16) with no reads -> w_full=1 after 16th edge, level=16;
//   17th write ignored, level stays 16.
// - FWFT=0: fill 3 words A,B,C, assert r_en 3 cycles -> r_data=A,B,C on successive edges,
//   r_empty=1 after 3rd; 4th r_en ignored, r_data stays C.
// - FWFT=1: single write 0x5A into empty -> next cycle r_empty=0, r_data=0x5A before any r_en;
//   pop -> r_empty=1.
// - DEPTH=5: 12 writes/reads interleaved, 1 word in flight -> data order preserved across pointer
//   wrap 4->0, level toggles 0/1.
// - level=16, simultaneous w_en+r_en -> write blocked, read done, level=15.
//   level=0, simultaneous -> read ignored, level=1.
// - AF_LEVEL=12, AE_LEVEL=2: almost_empty=1 at level 2, 0 at 3. almost_full=0 at 11, 1 at 12.
//   rst_n low mid-fill -> all flags at reset values next cycle.
//   With SYNC_FIFO_FLEX_ERR_FLAGS_EN, write at full -> overflow_err=1 until reset.

Source files
------------

// File: rtl/sync_fifo_flex.sv
// ---------------------------------------------------------------------------
// sync_fifo_flex
//   Single-clock FIFO for buffering between pipeline stages in one clock
//   domain. Any DEPTH >= 2 is supported, including non-powers of two.
//   The block provides a fill level, almost-full and almost-empty thresholds,
//   and either a standard read or a first-word-fall-through (FWFT) read.
//
// Parameters
//   DATA_WIDTH  word width in bits
//   DEPTH       storage words (>= 2, any integer)
//   AF_LEVEL    almost_full  = (level >= AF_LEVEL), 1..DEPTH
//   AE_LEVEL    almost_empty = (level <= AE_LEVEL), 0..DEPTH-1
//   FWFT        0 = standard read (1-cycle latency), 1 = first-word-fall-through
//
// Ports
//   clk           in   clock, all logic on posedge
//   rst_n         in   synchronous reset, active low
//   w_en/w_data   in   write request and data (accepted iff w_en && !w_full)
//   w_full        out  level == DEPTH
//   almost_full   out  level >= AF_LEVEL
//   r_en          in   read request, pops the head word in FWFT mode
//                      (accepted iff r_en && !r_empty)
//   r_data        out  registered read data
//   r_empty       out  no word readable
//   almost_empty  out  level <= AE_LEVEL
//   level         out  words held, including the FWFT output register
//
// Handshake: a request is accepted on a rising edge where the request is
//   high and the opposing flag (w_full / r_empty) is low at that edge.
//   Requests that are not accepted are dropped. They have no side effect
//   beyond the optional sticky error flags.
//
// Optional feature, macro SYNC_FIFO_FLEX_ERR_FLAGS_EN:
//   overflow_err   out  sticky, set on w_en && w_full
//   underflow_err  out  sticky, set on r_en && r_empty
//   Both flags are cleared only by reset.
// ---------------------------------------------------------------------------
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       w_en,
  input  logic [DATA_WIDTH-1:0]      w_data,
  output logic                       w_full,
  output logic                       almost_full,
  input  logic                       r_en,
  output logic [DATA_WIDTH-1:0]      r_data,
  output logic                       r_empty,
  output logic                       almost_empty,
`ifdef SYNC_FIFO_FLEX_ERR_FLAGS_EN
  output logic                       overflow_err,
  output logic                       underflow_err,
`endif
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam bit IS_FWFT = (FWFT != 0);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AF_LEVEL);
  localparam logic [LW-1:0] LVL_AE   = LW'(AE_LEVEL);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LW-1:0]         level_q;
  logic [LW-1:0]         level_nxt;

  logic wr_ok;
  logic rd_ok;
  logic mem_rd;
  logic mem_wr;
  logic bypass;
  logic load;
  logic mem_has;

  assign wr_ok = w_en && !w_full;
  assign rd_ok = r_en && !r_empty;
  assign level = level_q;

  // In FWFT mode the output register always holds the head word whenever
  // level > 0. Storage therefore holds level-1 words.
  assign mem_has = (level_q > LVL_ONE);
  assign load    = (level_q == '0) || rd_ok;

  always_comb begin
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    bypass = 1'b0;
    if (IS_FWFT) begin
      if (load) begin
        if (mem_has) begin
          mem_rd = 1'b1;
        end else if (wr_ok) begin
          // Storage is empty, so the incoming word goes straight to the
          // output register and is never written to memory.
          bypass = 1'b1;
        end
      end
      mem_wr = wr_ok && !bypass;
    end else begin
      mem_rd = rd_ok;
      mem_wr = wr_ok;
    end
  end

  always_comb begin
    level_nxt = level_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   level_nxt = level_q + LVL_ONE;
      2'b01:   level_nxt = level_q - LVL_ONE;
      default: level_nxt = level_q;
    endcase
  end

  // The storage array has no reset. Its contents are only meaningful below
  // the level register, and reset clears the level register.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[wr_ptr] <= w_data;
    end
  end

  // The flags are registered from the next level. They change in the same
  // cycle as level, and each one comes straight from a flop, so they cannot
  // glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_q      <= '0;
      r_data       <= '0;
      r_empty      <= 1'b1;
      w_full       <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      if (mem_wr) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (mem_rd) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
        r_data <= mem[rd_ptr];
      end else if (bypass) begin
        r_data <= w_data;
      end
      level_q      <= level_nxt;
      r_empty      <= (level_nxt == '0);
      w_full       <= (level_nxt == LVL_FULL);
      almost_empty <= (level_nxt <= LVL_AE);
      almost_full  <= (level_nxt >= LVL_AF);
    end
  end

`ifdef SYNC_FIFO_FLEX_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (w_en && w_full) overflow_err <= 1'b1;
      if (r_en && r_empty) underflow_err <= 1'b1;
    end
  end
`endif

endmodule
